hazard_stall_ctrl: RTL and testbench

Parametrised pipeline hazard/stall controller for the 5-stage core. It is the next generation of the load-interlock unit.
- Detects load-use hazards between the EX and ID stages using explicit source-use flags instead of instruction-type decoding.
- Supports multi-cycle load latency, multi-cycle branch flush, and a memory-wait freeze handshake.
- Drives PC and pipeline-register enables and resets; sits beside the hazard/forwarding units in controlUnits.

---
 rtl/hazard_stall_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Pipeline hazard/stall controller for the 5-stage core.
//                Detects load-use hazards from explicit source-use flags,
//                applies multi-cycle load stalls and branch flushes, and
//                freezes the pipeline while data memory is busy.
//                Optional macro HAZARD_PERF_EN adds saturating performance
//                counters for load stalls, flushes and memory waits.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
   parameter int REG_W       = 5,
   parameter int LOAD_LAT    = 1,
   parameter int FLUSH_DEPTH = 1,
   parameter int PERF_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             branchTaken,
   input  logic             exIsLoad,
   input  logic [REG_W-1:0] exRegDest,
   input  logic [REG_W-1:0] decRS,
   input  logic [REG_W-1:0] decRT,
   input  logic             decUsesRS,
   input  logic             decUsesRT,
   input  logic             memBusy,
   output logic             enPC,
   output logic             enIfId,
   output logic             enIdEx,
   output logic             rstIfId,
   output logic             rstIdEx,
`ifdef HAZARD_PERF_EN
   output logic [PERF_W-1:0] loadStallCycles,
   output logic [PERF_W-1:0] flushCycles,
   output logic [PERF_W-1:0] memWaitCycles,
`endif
   output logic             stallActive
);

   // Counter must hold the larger of the two reload values.
   localparam int c_CNT_MAX = (LOAD_LAT > FLUSH_DEPTH) ? LOAD_LAT : FLUSH_DEPTH;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;

   localparam logic [c_CNT_W-1:0] c_LOAD_RELOAD  = c_CNT_W'(LOAD_LAT - 1);
   localparam logic [c_CNT_W-1:0] c_FLUSH_RELOAD = c_CNT_W'(FLUSH_DEPTH - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_LSTALL = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic               w_hz;

   // Load-use hazard: EX load writes a register the ID instruction reads.
   // Register 0 is hard-wired, so it never creates a dependency.
   assign w_hz = exIsLoad && (exRegDest != '0) &&
                 ((decUsesRS && (decRS == exRegDest)) ||
                  (decUsesRT && (decRT == exRegDest)));

   // State and down-counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state and output decode; priority rst > memBusy > branch > hazard.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      enPC        = 1'b1;
      enIfId      = 1'b1;
      enIdEx      = 1'b1;
      rstIfId     = 1'b0;
      rstIdEx     = 1'b0;
      stallActive = 1'b0;

      if (rst) begin
         enPC        = 1'b0;
         enIfId      = 1'b0;
         enIdEx      = 1'b0;
         rstIfId     = 1'b1;
         rstIdEx     = 1'b1;
         w_state_nxt = ST_RUN;
         w_cnt_nxt   = '0;
      end else if (memBusy) begin
         // Full freeze: nothing moves, nothing is cleared, state holds.
         enPC        = 1'b0;
         enIfId      = 1'b0;
         enIdEx      = 1'b0;
         stallActive = 1'b1;
      end else if (branchTaken) begin
         // ID and IF hold wrong-path instructions: squash both, any
         // pending load stall is dropped along with them.
         rstIfId     = 1'b1;
         rstIdEx     = 1'b1;
         stallActive = 1'b1;
         if (FLUSH_DEPTH > 1) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = c_FLUSH_RELOAD;
         end else begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
         end
      end else begin
         case (r_state)
            ST_FLUSH: begin
               // ID already holds a bubble, so hazards are not checked here.
               rstIfId     = 1'b1;
               stallActive = 1'b1;
               if (r_cnt == c_CNT_ONE) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt   = r_cnt - c_CNT_ONE;
               end
            end
            ST_LSTALL: begin
               enPC        = 1'b0;
               enIfId      = 1'b0;
               rstIdEx     = 1'b1;
               stallActive = 1'b1;
               if (r_cnt == c_CNT_ONE) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt   = r_cnt - c_CNT_ONE;
               end
            end
            default: begin
               w_state_nxt = ST_RUN;
               if (w_hz) begin
                  // First bubble is inserted in the detection cycle.
                  enPC        = 1'b0;
                  enIfId      = 1'b0;
                  rstIdEx     = 1'b1;
                  stallActive = 1'b1;
                  if (LOAD_LAT > 1) begin
                     w_state_nxt = ST_LSTALL;
                     w_cnt_nxt   = c_LOAD_RELOAD;
                  end
               end
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic w_perf_ld;
   logic w_perf_fl;
   logic w_perf_mem;

   assign w_perf_mem = memBusy;
   assign w_perf_fl  = !memBusy && (branchTaken || (r_state == ST_FLUSH));
   assign w_perf_ld  = !memBusy && !branchTaken &&
                       ((r_state == ST_LSTALL) || ((r_state == ST_RUN) && w_hz));

   // Saturating event counters, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         loadStallCycles <= '0;
         flushCycles     <= '0;
         memWaitCycles   <= '0;
      end else begin
         if (w_perf_ld && !(&loadStallCycles))
            loadStallCycles <= loadStallCycles + 1'b1;
         if (w_perf_fl && !(&flushCycles))
            flushCycles <= flushCycles + 1'b1;
         if (w_perf_mem && !(&memWaitCycles))
            memWaitCycles <= memWaitCycles + 1'b1;
      end
   end
`else
   // Performance counters not present in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Self-checking bench for hazard_stall_ctrl (LOAD_LAT=3,
//                FLUSH_DEPTH=2) with directed and randomized steps against a
//                bubble/flush-count reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

   localparam int REG_W       = 5;
   localparam int LOAD_LAT    = 3;
   localparam int FLUSH_DEPTH = 2;
   localparam int PERF_W      = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             branchTaken = 1'b0;
   logic             exIsLoad = 1'b0;
   logic [REG_W-1:0] exRegDest = '0;
   logic [REG_W-1:0] decRS = '0;
   logic [REG_W-1:0] decRT = '0;
   logic             decUsesRS = 1'b0;
   logic             decUsesRT = 1'b0;
   logic             memBusy = 1'b0;
   logic             enPC, enIfId, enIdEx, rstIfId, rstIdEx, stallActive;
`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] loadStallCycles, flushCycles, memWaitCycles;
`endif

   int checks   = 0;
   int failures = 0;

   // Model state: bubbles / flush cycles still owed, and event tallies.
   int m_stall_left = 0;
   int m_flush_left = 0;
   int m_ld  = 0;
   int m_fl  = 0;
   int m_mem = 0;

   hazard_stall_ctrl #(
      .REG_W      (REG_W),
      .LOAD_LAT   (LOAD_LAT),
      .FLUSH_DEPTH(FLUSH_DEPTH),
      .PERF_W     (PERF_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .branchTaken(branchTaken),
      .exIsLoad   (exIsLoad),
      .exRegDest  (exRegDest),
      .decRS      (decRS),
      .decRT      (decRT),
      .decUsesRS  (decUsesRS),
      .decUsesRT  (decUsesRT),
      .memBusy    (memBusy),
      .enPC       (enPC),
      .enIfId     (enIfId),
      .enIdEx     (enIdEx),
      .rstIfId    (rstIfId),
      .rstIdEx    (rstIdEx),
`ifdef HAZARD_PERF_EN
      .loadStallCycles(loadStallCycles),
      .flushCycles    (flushCycles),
      .memWaitCycles  (memWaitCycles),
`endif
      .stallActive(stallActive)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Drive one cycle of inputs at the falling edge, check outputs 1ns later,
   // then advance the model to what the next rising edge should produce.
   task automatic step(input string tag, input logic r, input logic br,
                       input logic ld, input logic [REG_W-1:0] dst,
                       input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic urs, input logic urt, input logic mb);
      logic [5:0] exp_v;
      logic [5:0] obs_v;
      bit         hz;
      @(negedge clk);
      rst = r; branchTaken = br; exIsLoad = ld; exRegDest = dst;
      decRS = rs; decRT = rt; decUsesRS = urs; decUsesRT = urt; memBusy = mb;
      #1;
      hz = ld && (dst != 0) && ((urs && rs == dst) || (urt && rt == dst));
      // Vector order: enPC enIfId enIdEx rstIfId rstIdEx stallActive
      if (r)                      exp_v = 6'b000_110;
      else if (mb)                exp_v = 6'b000_001;
      else if (br)                exp_v = 6'b111_111;
      else if (m_flush_left > 0)  exp_v = 6'b111_101;
      else if (m_stall_left > 0)  exp_v = 6'b001_011;
      else if (hz)                exp_v = 6'b001_011;
      else                        exp_v = 6'b111_000;

      obs_v = {enPC, enIfId, enIdEx, rstIfId, rstIdEx, stallActive};
      checks++;
      assert (obs_v === exp_v) else begin
         failures++;
         $error("FAIL %s outputs observed=%b expected=%b", tag, obs_v, exp_v);
      end
`ifdef HAZARD_PERF_EN
      checks++;
      assert (loadStallCycles === PERF_W'(m_ld)) else begin
         failures++;
         $error("FAIL %s loadStallCycles observed=%0d expected=%0d", tag, loadStallCycles, m_ld);
      end
      checks++;
      assert (flushCycles === PERF_W'(m_fl)) else begin
         failures++;
         $error("FAIL %s flushCycles observed=%0d expected=%0d", tag, flushCycles, m_fl);
      end
      checks++;
      assert (memWaitCycles === PERF_W'(m_mem)) else begin
         failures++;
         $error("FAIL %s memWaitCycles observed=%0d expected=%0d", tag, memWaitCycles, m_mem);
      end
`endif

      if (r) begin
         m_stall_left = 0; m_flush_left = 0;
         m_ld = 0; m_fl = 0; m_mem = 0;
      end else if (mb) begin
         m_mem++;
      end else if (br) begin
         m_fl++;
         m_stall_left = 0;
         m_flush_left = FLUSH_DEPTH - 1;
      end else if (m_flush_left > 0) begin
         m_fl++;
         m_flush_left--;
      end else if (m_stall_left > 0) begin
         m_ld++;
         m_stall_left--;
      end else if (hz) begin
         m_ld++;
         m_stall_left = LOAD_LAT - 1;
      end
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic load_hz(input string tag);
      step(tag, 0, 0, 1, 5, 5, 0, 1, 0, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);

      // Reset state.
      step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("reset_hz_ignored", 1, 1, 1, 5, 5, 5, 1, 1, 1);

      // Single hazard: LOAD_LAT bubbles then run.
      load_hz("ld_hz");
      idle("ld_tail", 4);

      // RT match masked by decUsesRT=0, and destination 0.
      step("rt_masked", 0, 0, 1, 5, 3, 5, 1, 0, 0);
      step("dest_zero", 0, 0, 1, 0, 0, 0, 1, 1, 0);
      step("rt_used", 0, 0, 1, 7, 2, 7, 0, 1, 0);
      idle("rt_tail", 3);

      // Branch flush pulse.
      step("branch", 0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle("flush_tail", 3);

      // Branch in the 2nd LSTALL cycle aborts the load stall.
      load_hz("abort_hz");
      idle("abort_ls1", 1);
      step("abort_br", 0, 1, 1, 5, 5, 0, 1, 0, 0);
      idle("abort_tail", 3);

      // Branch arriving during FLUSH reloads the flush.
      step("br_a", 0, 1, 0, 0, 0, 0, 0, 0, 0);
      step("br_b", 0, 1, 0, 0, 0, 0, 0, 0, 0);
      step("br_hz_in_flush", 0, 0, 1, 5, 5, 0, 1, 0, 0);
      idle("br_tail", 2);

      // Memory freeze during LSTALL with counter=2, counters from clean reset.
      step("perf_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      load_hz("mem_hz");
      for (int i = 0; i < 4; i++) step("mem_busy", 0, 1, 1, 5, 5, 5, 1, 1, 1);
      idle("mem_resume", 4);

      // Reset in the middle of LSTALL.
      load_hz("mid_hz");
      step("mid_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle("mid_after", 2);

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         logic r, br, ld, urs, urt, mb;
         logic [REG_W-1:0] dst, rs, rt;
         r   = ($urandom_range(0, 39) == 0);
         mb  = ($urandom_range(0, 5) == 0);
         br  = ($urandom_range(0, 7) == 0);
         ld  = $urandom_range(0, 1) == 1;
         urs = $urandom_range(0, 1) == 1;
         urt = $urandom_range(0, 1) == 1;
         dst = REG_W'($urandom_range(0, 3));
         rs  = REG_W'($urandom_range(0, 3));
         rt  = REG_W'($urandom_range(0, 3));
         step("random", r, br, ld, dst, rs, rt, urs, urt, mb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
